// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake and completion status between a requester and the
// PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit/request, shift one odd-parity
// frame out on device clock falls, then check the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned REQ_CYCLES     = 200,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ps2_host_tx_if.slave        tx_if,
    input  logic                ps2_clk_i,
    input  logic                ps2_data_i,
    output logic                ps2_clk_oe_o,
    output logic                ps2_data_oe_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_REQ, ST_SEND,
        ST_ACK, ST_WAIT_IDLE, ST_DONE, ST_ERR
    } state_e;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [9:0]  frame_q, frame_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  clk_sync_q, data_sync_q;
    logic        clk_filt_q, clk_filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic        send_oe_s;
    logic        fall_s;

    // Glitch filter: the level moves only after FILTER_LEN differing samples
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
    end

    assign fall_s = clk_filt_q & ~clk_filt_d;

    // Next-state, counters and registered output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        send_oe_s = data_oe_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = 32'd0;
                tmo_d     = 32'd0;
                bit_cnt_d = 4'd0;
                if (tx_if.tx_valid && ready_q) begin
                    frame_d = {1'b1, odd_parity(tx_if.tx_data), tx_if.tx_data};
                    state_d = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == 32'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = 32'd0;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_REQ: begin
                if (cnt_q == 32'(REQ_CYCLES - 1)) begin
                    cnt_d     = 32'd0;
                    tmo_d     = 32'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SEND: begin
                tmo_d = tmo_q + 32'd1;
                if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else if (fall_s) begin
                    // frame_q[9] is the stop bit, so the line is released on the last fall
                    send_oe_s = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_ACK: begin
                tmo_d = tmo_q + 32'd1;
                if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else if (fall_s) begin
                    state_d = data_sync_q[1] ? ST_ERR : ST_WAIT_IDLE;
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_WAIT_IDLE: begin
                tmo_d = tmo_q + 32'd1;
                if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else if (clk_filt_q && data_sync_q[1]) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        case (state_d)
            ST_REQ:  data_oe_d = 1'b1;
            ST_SEND: data_oe_d = send_oe_s;
            default: data_oe_d = 1'b0;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_ERR);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 32'd0;
            tmo_q       <= 32'd0;
            bit_cnt_q   <= 4'd0;
            frame_q     <= 10'd0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    assign tx_if.tx_ready = ready_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.tx_done  = done_q;
    assign tx_if.tx_err   = err_q;
    assign ps2_clk_oe_o   = clk_oe_q;
    assign ps2_data_oe_o  = data_oe_q;

endmodule
